cascade_ack_controller: RTL

//  Clocked, parametrised successor to the 8259 cascade/vector logic. Sequences the INTA

---
 rtl/cascade_ack_controller.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/cascade_ack_controller.sv
// cascade_ack_controller: INTA pulse sequencer, CAS master/slave and vector/CALL byte driver.
// Ports: CLK/RST (sync, active-high); INTA_N acknowledge; SP_EN/SNGL/MODE_8086 and
//   ICW2/ICW3/ADDR_LO configuration; IR_GRANT/IR_VALID from the resolver; CAS_IN/CAS_OUT/CAS_OE
//   cascade bus; DOUT/DOUT_OE data byte; ISR_SET/ISR_IDX in-service strobe; SEQ_DONE end strobe.
module cascade_ack_controller #(
  parameter int NUM_IR = 8,
  parameter int CAS_W  = 3,
  parameter int VEC_W  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      INTA_N,
  input  logic                      SP_EN,
  input  logic                      SNGL,
  input  logic                      MODE_8086,
  input  logic [VEC_W-1:0]          ICW2,
  input  logic [NUM_IR-1:0]         ICW3,
  input  logic [2:0]                ADDR_LO,
  input  logic [NUM_IR-1:0]         IR_GRANT,
  input  logic                      IR_VALID,
  input  logic [CAS_W-1:0]          CAS_IN,
  output logic [CAS_W-1:0]          CAS_OUT,
  output logic                      CAS_OE,
  output logic [VEC_W-1:0]          DOUT,
  output logic                      DOUT_OE,
  output logic                      ISR_SET,
  output logic [$clog2(NUM_IR)-1:0] ISR_IDX,
  output logic                      SEQ_DONE
);

  localparam int IDX_W = $clog2(NUM_IR);

  localparam logic [VEC_W-1:0] CALL_OP = VEC_W'(8'hCD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_G1,
    S_P2,
    S_G2,
    S_P3
  } state_t;

  state_t state;

  logic inta_q;
  logic lead;
  logic trail;

  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             mode_q;
  logic             slave_q;
  logic             resp_q;

  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] start_idx;
  logic             start_casc;
  logic             start_slave;
  logic             start_resp;
  logic             start_call;

  logic [CAS_W-1:0] slave_id;
  logic             cas_sel;

  logic [VEC_W-1:0] vec86;
  logic [VEC_W-1:0] addr80;
  logic [VEC_W-1:0] p2_byte;

  assign lead  = inta_q & ~INTA_N;
  assign trail = ~inta_q & INTA_N;

  // Lowest set bit wins on a multi-hot grant.
  always_comb begin
    grant_idx = IDX_W'(NUM_IR - 1);
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (IR_GRANT[i]) grant_idx = IDX_W'(i);
    end
  end

  // A spurious acknowledge is answered as the lowest-priority input.
  assign start_idx   = IR_VALID ? grant_idx : IDX_W'(NUM_IR - 1);
  assign start_casc  = SP_EN & ~SNGL & ICW3[start_idx];
  assign start_slave = ~SP_EN & ~SNGL;
  assign start_resp  = ~start_casc & ~start_slave;

  // A slave is not known to be selected before CAS is read,
  // so the CALL opcode in pulse 1 only comes from a non-slave.
  assign start_call  = start_resp & ~MODE_8086;

  assign slave_id = CAS_W'(ICW3);
  assign cas_sel  = (CAS_IN == slave_id);

  assign vec86  = {ICW2[VEC_W-1:IDX_W], idx_q};
  assign addr80 = VEC_W'({ADDR_LO, idx_q, 2'b00});

  assign p2_byte = mode_q ? vec86 : addr80;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      inta_q   <= 1'b1;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
      slave_q  <= 1'b0;
      resp_q   <= 1'b0;
      CAS_OUT  <= '0;
      CAS_OE   <= 1'b0;
      DOUT     <= '0;
      DOUT_OE  <= 1'b0;
      ISR_SET  <= 1'b0;
      ISR_IDX  <= '0;
      SEQ_DONE <= 1'b0;
    end else begin
      inta_q   <= INTA_N;
      ISR_SET  <= 1'b0;
      SEQ_DONE <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (lead) begin
            state   <= S_P1;
            idx_q   <= start_idx;
            valid_q <= IR_VALID;
            mode_q  <= MODE_8086;
            slave_q <= start_slave;
            resp_q  <= start_resp;
            ISR_IDX <= start_idx;
            ISR_SET <= start_resp & IR_VALID;
            CAS_OE  <= start_casc;
            CAS_OUT <= start_casc ? CAS_W'(start_idx) : '0;
            DOUT_OE <= start_call;
            DOUT    <= start_call ? CALL_OP : '0;
          end
        end

        S_P1: begin
          if (trail) begin
            state   <= S_G1;
            DOUT_OE <= 1'b0;
            DOUT    <= '0;
            // Slaves learn they own the sequence only now.
            if (slave_q) begin
              resp_q  <= cas_sel;
              ISR_SET <= cas_sel & valid_q;
            end
          end
        end

        S_G1: begin
          if (lead) begin
            state   <= S_P2;
            DOUT_OE <= resp_q;
            DOUT    <= resp_q ? p2_byte : '0;
          end
        end

        S_P2: begin
          if (trail) begin
            DOUT_OE <= 1'b0;
            DOUT    <= '0;
            if (mode_q) begin
              state    <= S_IDLE;
              SEQ_DONE <= 1'b1;
              CAS_OE   <= 1'b0;
              CAS_OUT  <= '0;
            end else begin
              state <= S_G2;
            end
          end
        end

        S_G2: begin
          if (lead) begin
            state   <= S_P3;
            DOUT_OE <= resp_q;
            DOUT    <= resp_q ? ICW2 : '0;
          end
        end

        S_P3: begin
          if (trail) begin
            state    <= S_IDLE;
            SEQ_DONE <= 1'b1;
            DOUT_OE  <= 1'b0;
            DOUT     <= '0;
            CAS_OE   <= 1'b0;
            CAS_OUT  <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
